// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute issue register.
// Decodes RV32I-style opcode/funct3/funct7 into a 4-bit ALU op and selects the
// ALU operands. Decoded ops are held in a two-entry skid buffer (main + skid)
// with valid/ready handshakes on both sides, and the whole stage can be flushed.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_control,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_ILL  = 4'b1111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [RD_W-1:0] rd;
    logic            ill;
  } op_t;

  // Turns raw instruction fields into the operands and ALU op the execute
  // stage expects. Illegal encodings zero both operands so the ALU sees a
  // harmless input.
  function automatic op_t decode(
    input logic [6:0]      opc,
    input logic [2:0]      f3,
    input logic [6:0]      f7,
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] rs2,
    input logic [XLEN-1:0] imm,
    input logic [RD_W-1:0] rd
  );
    op_t  r;
    logic is_r;
    r      = '0;
    r.rd   = rd;
    is_r   = (opc == OPC_R);
    if (opc == OPC_LUI) begin
      r.b    = imm;
      r.ctrl = ALU_ADD;
    end else if (is_r || (opc == OPC_I)) begin
      r.a = rs1;
      r.b = is_r ? rs2 : imm;
      case (f3)
        3'b000: begin
          if (is_r && (f7 == 7'b0100000)) r.ctrl = ALU_SUB;
          else if (is_r && (f7 != 7'b0000000)) r.ill = 1'b1;
          else r.ctrl = ALU_ADD;
        end
        3'b111: r.ctrl = ALU_AND;
        3'b110: r.ctrl = ALU_OR;
        3'b100: r.ctrl = ALU_XOR;
        3'b010: r.ctrl = ALU_SLT;
        3'b011: r.ctrl = ALU_SLTU;
        default: r.ill = 1'b1;
      endcase
      // Non-ADD/SUB R-type ops only accept a zero funct7.
      if (is_r && (f3 != 3'b000) && (f7 != 7'b0000000)) r.ill = 1'b1;
    end else begin
      r.ill = 1'b1;
    end
    if (r.ill) begin
      r.a    = '0;
      r.b    = '0;
      r.ctrl = ALU_ILL;
    end
    return r;
  endfunction

  op_t  main_q, main_d, skid_q, skid_d, dec_op;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic in_ready_q, in_ready_d;
  logic accept, consume;

  assign dec_op  = decode(in_opcode, in_funct3, in_funct7, in_rs1_val,
                          in_rs2_val, in_imm, in_rd);
  assign accept  = in_valid && in_ready_q && !flush;
  assign consume = main_vld_q && out_ready;

  // Next-state for the two-entry buffer: skid refills main first, so FIFO order holds.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || consume) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = dec_op;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = dec_op;
      end
    end else if (accept) begin
      skid_d     = dec_op;
      skid_vld_d = 1'b1;
    end
    in_ready_d = !skid_vld_d;
  end

  // State registers; reset clears data fields as well so outputs read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = main_vld_q;
  assign out_a           = main_q.a;
  assign out_b           = main_q.b;
  assign out_alu_control = main_q.ctrl;
  assign out_rd          = main_q.rd;
  assign out_illegal     = main_q.ill;

endmodule
